// File: rtl/piano_pkg.sv
// piano_pkg
// Shared constants and the sequencer state type for the note playback path.
// Defaults target a 50 MHz clk stepping the song at 8 steps per second
// through a 1200-row note ROM (13-bit address, 10-bit row).
package piano_pkg;

    localparam int CLK_HZ         = 50_000_000;
    localparam int STEP_HZ        = 8;
    localparam int TICKS_PER_STEP = CLK_HZ / STEP_HZ;

    localparam int SONG_LEN = 1200;
    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 10;
    localparam int WINDOW   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/note_sequencer_step_timer.sv
// step_timer
// Tempo tick counter. Counts 0..TICKS-1 and flags the terminal count.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset, clears the count
//   load_max preload the count to TICKS-1 (so the first fetch is immediate)
//   clear    restart the count at 0
//   inc      advance the count by one
//   tc       high while the count equals TICKS-1
// Priority: rst > load_max > clear > inc.
module step_timer #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_max,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(TICKS);
    localparam logic [CW-1:0] MAX = CW'(TICKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load_max) begin
            count <= MAX;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == MAX);

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
// Walks the note ROM at a fixed tempo, one address per step, captures each
// returned row and keeps a sliding window of the most recent rows.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start        begin playback from address 0 (accepted in IDLE or DONE)
//   pause        freezes the tempo while high (only in PLAY)
//   rom_addr     registered ROM address
//   rom_data     ROM row, valid two cycles after rom_addr changes
//   row_valid    one-cycle strobe when a new row is captured
//   row_data     most recently captured row
//   window       [DATA_W-1:0] newest row, higher slices progressively older
//   step_index   address of the next row to fetch
//   playing      high in PLAY/WAIT/LATCH
//   done         high in DONE
//
// state | meaning
// IDLE  | waiting for start after reset
// PLAY  | counting tempo ticks; fetch issued at terminal count
// WAIT  | ROM read in flight
// LATCH | ROM row valid; capture it and advance
// DONE  | last row captured; outputs held until restart
module note_sequencer #(
    parameter int TICKS_PER_STEP = piano_pkg::TICKS_PER_STEP,
    parameter int SONG_LEN       = piano_pkg::SONG_LEN,
    parameter int ADDR_W         = piano_pkg::ADDR_W,
    parameter int DATA_W         = piano_pkg::DATA_W,
    parameter int WINDOW         = piano_pkg::WINDOW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pause,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     row_valid,
    output logic [DATA_W-1:0]        row_data,
    output logic [WINDOW*DATA_W-1:0] window,
    output logic [ADDR_W-1:0]        step_index,
    output logic                     playing,
    output logic                     done
);

    import piano_pkg::*;

    localparam int WIN_BITS = WINDOW * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(SONG_LEN - 1);

    seq_state_t state;
    logic tick_load;
    logic tick_clear;
    logic tick_inc;
    logic tick_tc;

    // Timer runs through WAIT/LATCH so that the full step, fetch included,
    // spans exactly TICKS_PER_STEP cycles.
    always_comb begin
        tick_load  = 1'b0;
        tick_clear = 1'b0;
        tick_inc   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: tick_load = start;
            ST_PLAY: begin
                if (!pause) begin
                    tick_clear = tick_tc;
                    tick_inc   = !tick_tc;
                end
            end
            ST_WAIT, ST_LATCH: tick_inc = 1'b1;
            default: ;
        endcase
    end

    step_timer #(
        .TICKS (TICKS_PER_STEP)
    ) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .load_max (tick_load),
        .clear    (tick_clear),
        .inc      (tick_inc),
        .tc       (tick_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            row_data   <= '0;
            window     <= '0;
            step_index <= '0;
            row_valid  <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            row_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_PLAY;
                        step_index <= '0;
                        window     <= '0;
                        row_data   <= '0;
                        playing    <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (!pause && tick_tc) begin
                        rom_addr <= step_index;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    row_data  <= rom_data;
                    window    <= {window[WIN_BITS-DATA_W-1:0], rom_data};
                    row_valid <= 1'b1;
                    if (step_index == LAST_STEP) begin
                        state   <= ST_DONE;
                        playing <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        step_index <= step_index + ADDR_W'(1);
                        state      <= ST_PLAY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
